// File: rtl/cntr_n.sv
// Up/down counter with load, held-request double stepping,
// wrap or saturate arithmetic and registered boundary pulses.
module cntr_n #(
    parameter int WIDTH = 8,
    parameter int SAT   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             inc,
    input  logic             dec,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out,
    output logic [2:0]       o_state,
    output logic             ovf,
    output logic             unf
);

    typedef enum logic [2:0] {
        IDLE = 3'b000,
        LOAD = 3'b001,
        INC  = 3'b010,
        INC2 = 3'b011,
        DEC  = 3'b100,
        DEC2 = 3'b101,
        BAD6 = 3'b110,
        BAD7 = 3'b111
    } state_e;

    localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic [WIDTH:0]   step;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;

    always_comb begin
        state_d = IDLE;
        if (state_q == BAD6 || state_q == BAD7) begin
            state_d = IDLE;
        end else if (load) begin
            state_d = LOAD;
        end else if (inc && !dec) begin
            state_d = (state_q == INC || state_q == INC2) ? INC2 : INC;
        end else if (dec && !inc) begin
            state_d = (state_q == DEC || state_q == DEC2) ? DEC2 : DEC;
        end else begin
            state_d = IDLE;
        end
    end

    // Extra top bit carries out of / borrows from the WIDTH-bit count.
    always_comb begin
        step = (state_d == INC2 || state_d == DEC2)
             ? (WIDTH+1)'(2) : (WIDTH+1)'(1);
        sum  = {1'b0, cnt_q} + step;
        diff = {1'b0, cnt_q} - step;
    end

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        case (state_d)
            LOAD: begin
                cnt_d = d_in;
            end
            INC, INC2: begin
                ovf_d = sum[WIDTH];
                if (sum[WIDTH] && SAT != 0) begin
                    cnt_d = MAX;
                end else begin
                    cnt_d = sum[WIDTH-1:0];
                end
            end
            DEC, DEC2: begin
                unf_d = diff[WIDTH];
                if (diff[WIDTH] && SAT != 0) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = diff[WIDTH-1:0];
                end
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign d_out   = cnt_q;
    assign o_state = state_q;
    assign ovf     = ovf_q;
    assign unf     = unf_q;

endmodule

// File: tb/tb_cntr_n.sv
// Bench for cntr_n: wrap and saturate instances driven in parallel,
// checked every cycle against a run-length arithmetic model.
module tb_cntr_n;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0;
    logic       inc = 1'b0;
    logic       dec = 1'b0;
    logic [7:0] d_in = 8'h00;

    logic [7:0] q0, q1;
    logic [2:0] s0, s1;
    logic       ov0, ov1, un0, un1;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    cntr_n #(.WIDTH(8), .SAT(0)) u_wrap (
        .clk(clk), .reset(reset), .load(load), .inc(inc), .dec(dec),
        .d_in(d_in), .d_out(q0), .o_state(s0), .ovf(ov0), .unf(un0)
    );

    cntr_n #(.WIDTH(8), .SAT(1)) u_sat (
        .clk(clk), .reset(reset), .load(load), .inc(inc), .dec(dec),
        .d_in(d_in), .d_out(q1), .o_state(s1), .ovf(ov1), .unf(un1)
    );

    // Model: count as an integer, run direction 0=none 1=up 2=down.
    int m_cnt[2];
    bit m_ovf[2];
    bit m_unf[2];
    int m_code = 0;
    int m_dir = 0;

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0;
            m_ovf[k] = 0;
            m_unf[k] = 0;
        end
    end

    always @(posedge clk or posedge reset) begin
        int step;
        int t;
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                m_cnt[k] = 0; m_ovf[k] = 0; m_unf[k] = 0;
            end
            m_code = 0;
            m_dir = 0;
        end else if (load) begin
            for (int k = 0; k < 2; k++) begin
                m_cnt[k] = int'(d_in); m_ovf[k] = 0; m_unf[k] = 0;
            end
            m_code = 1;
            m_dir = 0;
        end else if (inc && !dec) begin
            step = (m_dir == 1) ? 2 : 1;
            m_code = (step == 2) ? 3 : 2;
            for (int k = 0; k < 2; k++) begin
                t = m_cnt[k] + step;
                m_ovf[k] = (t > 255);
                m_unf[k] = 0;
                if (t > 255) m_cnt[k] = (k == 1) ? 255 : t - 256;
                else m_cnt[k] = t;
            end
            m_dir = 1;
        end else if (dec && !inc) begin
            step = (m_dir == 2) ? 2 : 1;
            m_code = (step == 2) ? 5 : 4;
            for (int k = 0; k < 2; k++) begin
                t = m_cnt[k] - step;
                m_unf[k] = (t < 0);
                m_ovf[k] = 0;
                if (t < 0) m_cnt[k] = (k == 1) ? 0 : t + 256;
                else m_cnt[k] = t;
            end
            m_dir = 2;
        end else begin
            for (int k = 0; k < 2; k++) begin
                m_ovf[k] = 0; m_unf[k] = 0;
            end
            m_code = 0;
            m_dir = 0;
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h @%0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("wrap.d_out", 32'(q0), 32'(m_cnt[0]));
            chk("wrap.state", 32'(s0), 32'(m_code));
            chk("wrap.flags", {30'd0, ov0, un0}, {30'd0, m_ovf[0], m_unf[0]});
            chk("sat.d_out", 32'(q1), 32'(m_cnt[1]));
            chk("sat.state", 32'(s1), 32'(m_code));
            chk("sat.flags", {30'd0, ov1, un1}, {30'd0, m_ovf[1], m_unf[1]});
            chk("excl", {31'd0, (ov0 & un0) | (ov1 & un1)}, 32'd0);
        end
    end

    // Inputs change 1 time unit after a rising edge; returns after the next one.
    task automatic step(bit l, bit i, bit d, logic [7:0] v);
        load = l; inc = i; dec = d; d_in = v;
        @(posedge clk);
        #1;
    endtask

    task automatic lit(string n, logic [7:0] q, logic [2:0] s,
                       bit o, bit u, logic [7:0] eq, logic [2:0] es,
                       bit eo, bit eu);
        chk({n, ".d_out"}, 32'(q), 32'(eq));
        chk({n, ".state"}, 32'(s), 32'(es));
        chk({n, ".ovf"}, 32'(o), 32'(eo));
        chk({n, ".unf"}, 32'(u), 32'(eu));
    endtask

    initial begin
        logic [7:0] picks [6];
        int r;
        int dir;
        picks[0] = 8'h00; picks[1] = 8'h01; picks[2] = 8'h02;
        picks[3] = 8'hFD; picks[4] = 8'hFE; picks[5] = 8'hFF;

        // Reset, with a load request already pending.
        load = 1'b1; d_in = 8'h5A;
        #3;
        lit("rst_w", q0, s0, ov0, un0, 8'h00, 3'b000, 0, 0);
        lit("rst_s", q1, s1, ov1, un1, 8'h00, 3'b000, 0, 0);
        @(posedge clk); #1;
        lit("rst_hold", q0, s0, ov0, un0, 8'h00, 3'b000, 0, 0);
        reset = 1'b0;
        cmp_en = 1'b1;
        step(1, 0, 0, 8'h5A);
        lit("load5A", q0, s0, ov0, un0, 8'h5A, 3'b001, 0, 0);

        // Held increment.
        step(1, 0, 0, 8'h10);
        step(0, 1, 0, 8'hAA);
        lit("inc1", q0, s0, ov0, un0, 8'h11, 3'b010, 0, 0);
        step(0, 1, 0, 8'hAA);
        lit("inc2", q0, s0, ov0, un0, 8'h13, 3'b011, 0, 0);
        step(0, 1, 0, 8'hAA);
        lit("inc3", q0, s0, ov0, un0, 8'h15, 3'b011, 0, 0);
        step(0, 1, 0, 8'hAA);
        lit("inc4", q0, s0, ov0, un0, 8'h17, 3'b011, 0, 0);

        // Wrap and saturate on the upper boundary.
        step(1, 0, 0, 8'hFF);
        step(0, 1, 0, 8'h00);
        lit("wrapup1", q0, s0, ov0, un0, 8'h00, 3'b010, 1, 0);
        step(0, 1, 0, 8'h00);
        lit("wrapup2", q0, s0, ov0, un0, 8'h02, 3'b011, 0, 0);
        step(1, 0, 0, 8'hFE);
        step(0, 1, 0, 8'h00);
        lit("satup1", q1, s1, ov1, un1, 8'hFF, 3'b010, 0, 0);
        step(0, 1, 0, 8'h00);
        lit("satup2", q1, s1, ov1, un1, 8'hFF, 3'b011, 1, 0);
        step(0, 1, 0, 8'h00);
        lit("satup3", q1, s1, ov1, un1, 8'hFF, 3'b011, 1, 0);

        // Lower boundary.
        step(1, 0, 0, 8'h01);
        step(0, 0, 1, 8'h00);
        lit("wrapdn1", q0, s0, ov0, un0, 8'h00, 3'b100, 0, 0);
        lit("satdn1", q1, s1, ov1, un1, 8'h00, 3'b100, 0, 0);
        step(0, 0, 1, 8'h00);
        lit("wrapdn2", q0, s0, ov0, un0, 8'hFE, 3'b101, 0, 1);
        lit("satdn2", q1, s1, ov1, un1, 8'h00, 3'b101, 0, 1);

        // Priority and simultaneous requests.
        step(1, 1, 1, 8'h33);
        lit("prio", q0, s0, ov0, un0, 8'h33, 3'b001, 0, 0);
        step(0, 1, 1, 8'h99);
        lit("both", q0, s0, ov0, un0, 8'h33, 3'b000, 0, 0);
        step(0, 1, 0, 8'h99);
        lit("tog1", q0, s0, ov0, un0, 8'h34, 3'b010, 0, 0);
        step(0, 0, 1, 8'h99);
        lit("tog2", q0, s0, ov0, un0, 8'h33, 3'b100, 0, 0);
        step(0, 1, 0, 8'h99);
        lit("tog3", q0, s0, ov0, un0, 8'h34, 3'b010, 0, 0);

        // Asynchronous reset in the middle of a double-step run.
        step(1, 0, 0, 8'h3D);
        step(0, 1, 0, 8'h00);
        step(0, 1, 0, 8'h00);
        lit("pre_rst", q0, s0, ov0, un0, 8'h40, 3'b011, 0, 0);
        reset = 1'b1;
        #1;
        lit("async_w", q0, s0, ov0, un0, 8'h00, 3'b000, 0, 0);
        lit("async_s", q1, s1, ov1, un1, 8'h00, 3'b000, 0, 0);
        #1;
        reset = 1'b0;
        step(0, 1, 0, 8'h00);
        lit("post_rst", q0, s0, ov0, un0, 8'h01, 3'b010, 0, 0);

        // Randomised runs biased toward held requests and boundaries.
        dir = 1;
        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 6) begin
                if ($urandom_range(0, 1) == 1)
                    step(1, $urandom_range(0, 1) == 1,
                         $urandom_range(0, 1) == 1,
                         picks[$urandom_range(0, 5)]);
                else
                    step(1, 0, 0, 8'($urandom));
            end else if (r < 14) begin
                step(0, 0, 0, 8'($urandom));
            end else if (r < 19) begin
                step(0, 1, 1, 8'($urandom));
            end else if (r < 20) begin
                reset = 1'b1;
                #2;
                reset = 1'b0;
            end else begin
                if ($urandom_range(0, 99) < 25) dir = (dir == 1) ? 2 : 1;
                step(0, dir == 1, dir == 2, 8'($urandom));
            end
        end

        step(0, 0, 0, 8'h00);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
